logic_eval_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one evaluation unit for the Boolean function Result = a & (b | c) among NUM_REQ requesters. It sits between the requesting blocks and the shared evaluator. It performs arbitration, operand capture, evaluation and response delivery over a valid/ready response handshake. It also keeps a saturating count of completed evaluations.

---
 rtl/logic_eval_arbiter.sv | 119 +++++++++++
 tb/tb_logic_eval_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_arbiter.sv
// rtl/logic_eval_arbiter.sv - round-robin arbiter sharing one a & (b | c) evaluator
// Requesters are served one at a time; the response waits in RESP until accepted.
module logic_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  input  logic [NUM_REQ-1:0] op_c,
  output logic [NUM_REQ-1:0] grant,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_result,
  output logic               busy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   eval_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] last_id, cur_id;
  logic [ID_W-1:0] win_id, scan_id;
  logic            win_found;
  logic            cap_a, cap_b, cap_c;
  logic            accept;

  assign accept = (state == RESP) && rsp_ready;
  assign busy   = (state != IDLE);

  // Scan starts just after the last winner and wraps over the legal indices only.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = last_id;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_id = (scan_id == ID_W'(NUM_REQ - 1)) ? '0 : scan_id + 1'b1;
      if (!win_found && req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_found) state_n = EVAL;
      EVAL:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id    <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      cap_a      <= 1'b0;
      cap_b      <= 1'b0;
      cap_c      <= 1'b0;
      grant      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cap_a   <= op_a[win_id];
            cap_b   <= op_b[win_id];
            cap_c   <= op_c[win_id];
            cur_id  <= win_id;
            last_id <= win_id;
            // Registered so the pulse lands in the EVAL cycle.
            grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          end
        end
        EVAL: begin
          rsp_result <= cap_a & (cap_b | cap_c);
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over an accept on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_count <= '0;
    end else if (cnt_clr) begin
      eval_count <= '0;
    end else if (accept && (eval_count != {CNT_W{1'b1}})) begin
      eval_count <= eval_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// tb/tb_logic_eval_arbiter.sv - self-checking bench for logic_eval_arbiter
// Transaction-level model checked every cycle plus directed literal checks.
module tb_logic_eval_arbiter;

  localparam int N    = 4;
  localparam int CMAX = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0, op_a = '0, op_b = '0, op_c = '0;
  logic         rsp_ready = 1'b0, cnt_clr = 1'b0;
  logic [N-1:0] grant;
  logic         rsp_valid, rsp_result, busy;
  logic [1:0]   rsp_id;
  logic [3:0]   eval_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic_eval_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy), .cnt_clr(cnt_clr), .eval_count(eval_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one in-flight transaction with its age in cycles since capture.
  int m_last = N - 1;
  bit m_infl = 1'b0;
  int m_age = 0;
  int m_id = 0;
  int m_res = 0;
  int m_cnt = 0;
  bit m_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last = N - 1; m_infl = 1'b0; m_age = 0; m_cnt = 0;
    end else begin
      m_acc = m_infl && (m_age >= 2) && rsp_ready;
      if (cnt_clr) m_cnt = 0;
      else if (m_acc && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (m_acc) m_infl = 1'b0;
      else if (m_infl) m_age = m_age + 1;
      else if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!m_infl && req[idx]) begin
            m_infl = 1'b1; m_age = 1; m_id = idx; m_last = idx;
            m_res = int'(op_a[idx] & (op_b[idx] | op_c[idx]));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] eg;
      eg = (m_infl && m_age == 1) ? N'(1 << m_id) : '0;
      check("grant", grant, eg);
      check("rsp_valid", rsp_valid, m_infl && m_age >= 2);
      check("busy", busy, m_infl);
      check("eval_count", eval_count, m_cnt);
      if (m_infl && m_age >= 2) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_result", rsp_result, m_res);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst grant", grant, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_id", rsp_id, 0);
    check("rst rsp_result", rsp_result, 0);
    check("rst busy", busy, 0);
    check("rst eval_count", eval_count, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic txn(input int id, input bit a, input bit b, input bit c, input bit exp);
    op_a = N'($urandom); op_b = N'($urandom); op_c = N'($urandom);
    op_a[id] = a; op_b[id] = b; op_c[id] = c;
    req = N'(1 << id);
    rsp_ready = 1'b1;
    tick();
    check("txn grant", grant, 1 << id);
    req = '0;
    tick();
    check("txn rsp_valid", rsp_valid, 1);
    check("txn rsp_id", rsp_id, id);
    check("txn rsp_result", rsp_result, exp);
    tick();
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  int tt[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
  int rr[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

  initial begin
    do_reset();

    // First transaction after reset.
    txn(0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("count after first", eval_count, 1);

    // Truth table through requester 2.
    clear_count();
    for (int v = 0; v < 8; v++) begin
      txn(2, v[2], v[1], v[0], tt[v][0]);
    end
    check("count after table", eval_count, 8);

    // Round-robin order, then req=1010 after last_id=1.
    do_reset();
    req = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr grant", grant, 1 << rr[i]);
      if (i == 5) req = 4'b1010;
      tick();
      tick();
    end
    req = '0;
    tick();
    tick();
    tick();

    // Backpressure with toggling operands.
    clear_count();
    rsp_ready = 1'b0;
    op_a = 4'b0001; op_b = 4'b0001; op_c = 4'b0000;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_id", rsp_id, 0);
      check("bp rsp_result", rsp_result, 1);
      check("bp busy", busy, 1);
      check("bp grant", grant, 0);
      op_a = N'($urandom); op_b = N'($urandom); op_c = N'($urandom);
      req = N'($urandom);
      tick();
    end
    req = '0;
    rsp_ready = 1'b1;
    tick();
    check("bp count", eval_count, 1);
    check("bp released", rsp_valid, 0);

    // Saturation and clear-vs-accept.
    clear_count();
    for (int i = 0; i < 17; i++) begin
      bit a, b, c;
      a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
      txn(int'($urandom_range(0, N - 1)), a, b, c, a & (b | c));
    end
    check("count saturated", eval_count, 15);
    rsp_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    rsp_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clear beats accept", eval_count, 0);
    check("clr accept valid", rsp_valid, 0);

    // Reset during EVAL and during RESP.
    txn(1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("count before rst", eval_count, 1);
    req = 4'b0100;
    tick();
    check("eval busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst eval grant", grant, 0);
    check("rst eval busy", busy, 0);
    check("rst eval count", eval_count, 0);
    tick();
    rst_n = 1'b1;
    req = 4'b1000;
    tick();
    check("post rst grant3", grant, 4'b1000);
    req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst resp valid", rsp_valid, 0);
    check("rst resp busy", busy, 0);
    check("rst resp id", rsp_id, 0);
    check("rst resp result", rsp_result, 0);
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    check("post rst grant0", grant, 4'b0001);
    req = '0;
    tick();
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req = N'($urandom);
      op_a = N'($urandom); op_b = N'($urandom); op_c = N'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      cnt_clr = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
